y86_fetch_dreg: RTL and testbench
=================================

Name: y86_fetch_dreg

Overview:
- Y86-64 fetch stage plus the F (predicted-PC) and D pipeline registers, in front of decode.
- Selects the fetch PC, splits the 10 instruction bytes from instruction memory, computes valP, predicts the next PC and produces f_stat.
- Applies F_stall, D_stall and D_bubble from the pipeline control unit to its two registers.

Parameters:
- RESET_PC, 64'h0, value loaded into F_predPC on reset.
- CNT_W, 32, width of the performance counters (used only with PERF_CNT_EN).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- F_stall  in  1  hold F_predPC
- D_stall  in  1  hold the D register
- D_bubble  in  1  load a bubble into the D register
- M_icode  in  4  memory-stage icode (misprediction recovery)
- M_Cnd  in  1  memory-stage branch condition
- M_valA  in  64  fall-through PC of a mispredicted jXX
- W_icode  in  4  write-back icode (ret recovery)
- W_valM  in  64  return address of ret
- imem_bytes  in  80  bytes at f_pc; byte k = imem_bytes[8k+7:8k]
- imem_error  in  1  f_pc out of range
- f_pc  out  64  selected fetch PC, to instruction memory
- D_stat  out  3  AOK=1, HLT=2, ADR=3, INS=4
- D_icode, D_ifun, D_rA, D_rB  out  4 each
- D_valC, D_valP  out  64 each

Behaviour:
- PC select, combinational, in priority order:
  - M_icode==7 && !M_Cnd: f_pc = M_valA
  - else W_icode==9: f_pc = W_valM
  - else f_pc = F_predPC
- Split: byte0 = {icode, ifun}.
  - If imem_error, icode=1 (nop) and ifun=0.
- need_regids: icode in {2,3,4,5,6,A,B}; rA/rB = byte1[7:4]/[3:0], else rA=rB=4'hF.
- need_valC: icode in {3,4,5,7,8}.
  - valC = little-endian 8 bytes starting at byte1+need_regids; else 0.
- valP = f_pc + 1 + need_regids + 8*need_valC, 64-bit modulo; wrap past 2^64 is ignored.
- Predicted PC: valC for icode 7 or 8, otherwise valP.
- f_stat, in priority order:
  - imem_error: ADR
  - icode > 4'hB: INS
  - icode == 0: HLT
  - otherwise AOK
- F register:
  - Reset: F_predPC = RESET_PC.
  - Each clock, load the predicted PC unless F_stall.
- D register reset / bubble value: stat=AOK, icode=1, ifun=0, rA=rB=F, valC=0, valP=0.
- D register per clock, in priority order:
  - D_stall: hold.
  - else D_bubble: load the bubble value.
  - else load the fetch results.
  - D_stall && D_bubble together: stall wins.
- Latency: one cycle from f_pc to the D outputs.
- Reset mid-operation clears both registers immediately; there is no pending state.
- Fetch never self-stops on HLT/ADR/INS. The status propagates, and the control unit stalls and bubbles downstream.

Optional Feature:
- Macro: Y86_PERF_CNT_EN.
- When defined, adds outputs stall_cnt, bubble_cnt and fetch_cnt, each CNT_W wide, all cleared by rst.
  - stall_cnt increments on cycles with D_stall.
  - bubble_cnt increments on cycles with D_bubble && !D_stall.
  - fetch_cnt increments on cycles where the D register loads a real instruction.
  - All three saturate at all-ones.
- When undefined, the ports and logic are absent; remaining behaviour is identical.

Decomposition:
- Package y86_pkg holds:
  - icode constants: I_HALT..I_POPQ
  - status codes: S_AOK, S_HLT, S_ADR, S_INS
  - RNONE = 4'hF
  - D-bubble constants
- Sub-module y86_instr_split (combinational): imem_bytes and imem_error in; icode, ifun, rA, rB, valC, need_regids, need_valC and instr_valid out.

Test Plan:
- Reset, then imem_bytes = irmovq $0x1122334455667788,%rbx (30 F3 88 77 66 55 44 33 22 11) at PC 0 -> next cycle D_icode=3, D_rB=3, D_rA=F, D_valC=64'h1122334455667788, D_valP=10, F_predPC=10.
- jXX at PC 0x20 with valC=0x100, then M_icode=7 with M_Cnd=0 and M_valA=0x29 -> f_pc=0x29 that cycle; with D_bubble=1 the next D_icode=1 and D_stat=AOK.
- W_icode=9, W_valM=0x400 while M_icode=7 and M_Cnd=0 -> f_pc=M_valA (misprediction wins); with M_Cnd=1 -> f_pc=0x400.
- F_stall=D_stall=1 for 3 cycles -> F_predPC and all D outputs are constant. Assert D_stall and D_bubble together -> D holds.
- imem_error=1 -> D_stat=3 and D_icode=1. byte0=8'hC0 -> D_stat=4. byte0=8'h00 -> D_stat=2 and D_valP=f_pc+1.
- With Y86_PERF_CNT_EN: 5 stalls, 2 bubbles and 10 loads -> counters read 5, 2 and 10. Assert rst mid-run -> all counters are 0 and F_predPC=RESET_PC asynchronously.

Source files
------------

// File: rtl/y86_pkg.sv
// ============================================================================
// Module : y86_pkg
// Brief  : Shared Y86-64 icode, status and D-register definitions for fetch.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        rA:    RNONE,
        rB:    RNONE,
        valC:  64'h0,
        valP:  64'h0
    };

    function automatic logic f_need_regids(input logic [3:0] icode);
        return (icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                              I_OPQ, I_PUSHQ, I_POPQ});
    endfunction

    function automatic logic f_need_valc(input logic [3:0] icode);
        return (icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL});
    endfunction

endpackage

`default_nettype wire

// File: rtl/y86_instr_split.sv
// ============================================================================
// Module : y86_instr_split
// Brief  : Combinational split of the 10 fetched bytes into instruction fields.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_instr_split
    import y86_pkg::*;
(
    input  logic [79:0] i_imem_bytes,
    input  logic        i_imem_error,
    output logic [3:0]  o_icode,
    output logic [3:0]  o_ifun,
    output logic [3:0]  o_rA,
    output logic [3:0]  o_rB,
    output logic [63:0] o_valC,
    output logic        o_need_regids,
    output logic        o_need_valC,
    output logic        o_instr_valid
);

    // A bad fetch address is turned into a nop so no fields are consumed.
    assign o_icode       = i_imem_error ? I_NOP : i_imem_bytes[7:4];
    assign o_ifun        = i_imem_error ? 4'h0  : i_imem_bytes[3:0];
    assign o_need_regids = f_need_regids(o_icode);
    assign o_need_valC   = f_need_valc(o_icode);
    assign o_rA          = o_need_regids ? i_imem_bytes[15:12] : RNONE;
    assign o_rB          = o_need_regids ? i_imem_bytes[11:8]  : RNONE;
    assign o_valC        = !o_need_valC  ? 64'h0
                         : o_need_regids ? i_imem_bytes[79:16]
                         :                 i_imem_bytes[71:8];
    assign o_instr_valid = !i_imem_error && (o_icode <= I_POPQ);

endmodule

`default_nettype wire

// File: rtl/y86_fetch_dreg.sv
// ============================================================================
// Module : y86_fetch_dreg
// Brief  : Y86-64 fetch stage with F (predicted PC) and D pipeline registers.
//          Optional performance counters enabled by macro Y86_PERF_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_fetch_dreg
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              F_stall,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic [3:0]        M_icode,
    input  logic              M_Cnd,
    input  logic [63:0]       M_valA,
    input  logic [3:0]        W_icode,
    input  logic [63:0]       W_valM,
    input  logic [79:0]       imem_bytes,
    input  logic              imem_error,
    output logic [63:0]       f_pc,
    output logic [2:0]        D_stat,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [63:0]       D_valC,
    output logic [63:0]       D_valP
`ifdef Y86_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  fetch_cnt
`endif
);

    logic [63:0] r_pred_pc;
    d_reg_t      r_d;

    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    logic [3:0]  w_rA;
    logic [3:0]  w_rB;
    logic [63:0] w_valC;
    logic        w_need_regids;
    logic        w_need_valC;
    logic        w_instr_valid;
    logic [63:0] w_f_pc;
    logic [63:0] w_valP;
    logic [63:0] w_pred_pc;
    logic [2:0]  w_stat;
    d_reg_t      w_fetch;

    y86_instr_split u_split (
        .i_imem_bytes  (imem_bytes),
        .i_imem_error  (imem_error),
        .o_icode       (w_icode),
        .o_ifun        (w_ifun),
        .o_rA          (w_rA),
        .o_rB          (w_rB),
        .o_valC        (w_valC),
        .o_need_regids (w_need_regids),
        .o_need_valC   (w_need_valC),
        .o_instr_valid (w_instr_valid)
    );

    // Mispredicted branch recovery outranks ret recovery.
    always_comb begin
        w_f_pc = r_pred_pc;
        if (M_icode == I_JXX && !M_Cnd)
            w_f_pc = M_valA;
        else if (W_icode == I_RET)
            w_f_pc = W_valM;
    end

    assign w_valP    = w_f_pc + 64'd1 + {63'd0, w_need_regids} + {60'd0, w_need_valC, 3'b000};
    assign w_pred_pc = (w_icode == I_JXX || w_icode == I_CALL) ? w_valC : w_valP;

    always_comb begin
        w_stat = S_AOK;
        if (imem_error)
            w_stat = S_ADR;
        else if (w_icode > I_POPQ)
            w_stat = S_INS;
        else if (w_icode == I_HALT)
            w_stat = S_HLT;
    end

    assign w_fetch = '{stat: w_stat, icode: w_icode, ifun: w_ifun, rA: w_rA,
                       rB: w_rB, valC: w_valC, valP: w_valP};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pred_pc <= RESET_PC;
        else if (!F_stall)
            r_pred_pc <= w_pred_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_d <= D_BUBBLE;
        else if (D_stall)
            r_d <= r_d;
        else if (D_bubble)
            r_d <= D_BUBBLE;
        else
            r_d <= w_fetch;
    end

    assign f_pc    = w_f_pc;
    assign D_stat  = r_d.stat;
    assign D_icode = r_d.icode;
    assign D_ifun  = r_d.ifun;
    assign D_rA    = r_d.rA;
    assign D_rB    = r_d.rB;
    assign D_valC  = r_d.valC;
    assign D_valP  = r_d.valP;

`ifdef Y86_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic             w_load_real;

    assign w_load_real = !D_stall && !D_bubble && w_instr_valid;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_fetch_cnt  <= '0;
        end else begin
            if (D_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (D_bubble && !D_stall && r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (w_load_real && r_fetch_cnt != '1)
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign fetch_cnt  = r_fetch_cnt;
`else
    logic w_unused;
    assign w_unused = w_instr_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_y86_fetch_dreg.sv
// ============================================================================
// Module : tb_y86_fetch_dreg
// Brief  : Directed scoreboard bench for the Y86-64 fetch stage and D register.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_y86_fetch_dreg;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [79:0] imem_bytes;
    logic        imem_error;
    logic [63:0] f_pc;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;
`ifdef Y86_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
    logic [31:0] fetch_cnt;
`endif

    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    y86_fetch_dreg #(.RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .F_stall    (F_stall),
        .D_stall    (D_stall),
        .D_bubble   (D_bubble),
        .M_icode    (M_icode),
        .M_Cnd      (M_Cnd),
        .M_valA     (M_valA),
        .W_icode    (W_icode),
        .W_valM     (W_valM),
        .imem_bytes (imem_bytes),
        .imem_error (imem_error),
        .f_pc       (f_pc),
        .D_stat     (D_stat),
        .D_icode    (D_icode),
        .D_ifun     (D_ifun),
        .D_rA       (D_rA),
        .D_rB       (D_rB),
        .D_valC     (D_valC),
        .D_valP     (D_valP)
`ifdef Y86_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .fetch_cnt  (fetch_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc, input logic [63:0] vp);
        exp_t e;
        e = '{stat: st, icode: ic, ifun: fn, rA: ra, rB: rb, valC: vc, valP: vp};
        return e;
    endfunction

    task automatic chk_d(input string tag, input exp_t e);
        chk({tag, ".stat"},  {61'd0, D_stat},  {61'd0, e.stat});
        chk({tag, ".icode"}, {60'd0, D_icode}, {60'd0, e.icode});
        chk({tag, ".ifun"},  {60'd0, D_ifun},  {60'd0, e.ifun});
        chk({tag, ".rA"},    {60'd0, D_rA},    {60'd0, e.rA});
        chk({tag, ".rB"},    {60'd0, D_rB},    {60'd0, e.rB});
        chk({tag, ".valC"},  D_valC,           e.valC);
        chk({tag, ".valP"},  D_valP,           e.valP);
    endtask

    // Clock once, then pop the oldest expectation and compare the D register.
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk_d(tag, e);
        end
    endtask

    initial begin
        exp_t held;
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        F_stall    = 1'b0;
        D_stall    = 1'b0;
        D_bubble   = 1'b0;
        M_icode    = 4'h0;
        M_Cnd      = 1'b0;
        M_valA     = 64'h0;
        W_icode    = 4'h0;
        W_valM     = 64'h0;
        imem_bytes = 80'h0;
        imem_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_d("reset", mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0));
        chk("reset.f_pc", f_pc, 64'h0);
        rst = 1'b0;

        // irmovq $0x1122334455667788, %rbx at PC 0
        imem_bytes = {64'h1122334455667788, 8'hF3, 8'h30};
        #1 chk("irmovq.f_pc", f_pc, 64'h0);
        sb.push_back(mk(3'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'd10));
        step("irmovq");
        chk("irmovq.pred", f_pc, 64'd10);

        // jmp 0x20 at PC 10
        imem_bytes = {8'h00, 64'h20, 8'h70};
        sb.push_back(mk(3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'd19));
        step("jmp");
        chk("jmp.pred", f_pc, 64'h20);

        // jne 0x100 at PC 0x20, predicted taken
        imem_bytes = {8'h00, 64'h100, 8'h74};
        sb.push_back(mk(3'd1, 4'h7, 4'h4, 4'hF, 4'hF, 64'h100, 64'h29));
        step("jne");
        chk("jne.pred", f_pc, 64'h100);

        // Misprediction: M recovery beats a simultaneous ret
        M_icode    = 4'h7;
        M_Cnd      = 1'b0;
        M_valA     = 64'h29;
        W_icode    = 4'h9;
        W_valM     = 64'h400;
        imem_bytes = {72'h0, 8'h10};
        #1 chk("mispred.f_pc", f_pc, 64'h29);
        D_bubble = 1'b1;
        sb.push_back(mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0));
        step("bubble");
        D_bubble = 1'b0;
        M_Cnd    = 1'b1;
        #1 chk("ret.f_pc", f_pc, 64'h400);
        M_icode = 4'h0;
        W_icode = 4'h0;
        #1 chk("recovered.pred", f_pc, 64'h2A);

        // rrmovq %rax, %rcx at 0x2A
        imem_bytes = {64'h0, 8'h01, 8'h20};
        held = mk(3'd1, 4'h2, 4'h0, 4'h0, 4'h1, 64'h0, 64'h2C);
        sb.push_back(held);
        step("rrmovq");
        chk("rrmovq.pred", f_pc, 64'h2C);

        // Full stall for three cycles while memory shows something else
        F_stall    = 1'b1;
        D_stall    = 1'b1;
        imem_bytes = {64'h0, 8'h23, 8'h60};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(held);
            step("stall");
            chk("stall.pc", f_pc, 64'h2C);
        end

        // Stall and bubble together: D holds, F advances past addq
        F_stall  = 1'b0;
        D_bubble = 1'b1;
        sb.push_back(held);
        step("stall_bubble");
        chk("stall_bubble.pc", f_pc, 64'h2E);
        D_stall  = 1'b0;
        D_bubble = 1'b0;

        // Address error becomes an ADR nop
        imem_error = 1'b1;
        imem_bytes = {64'h0, 8'h23, 8'h60};
        sb.push_back(mk(3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2F));
        step("adr");
        imem_error = 1'b0;

        imem_bytes = {72'h0, 8'hC0};
        sb.push_back(mk(3'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h30));
        step("ins");

        imem_bytes = {72'h0, 8'h00};
        sb.push_back(mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h31));
        step("hlt");
        chk("hlt.pc", f_pc, 64'h31);

        // call 0x200 at 0x31
        imem_bytes = {8'h00, 64'h200, 8'h80};
        sb.push_back(mk(3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h3A));
        step("call");
        chk("call.pred", f_pc, 64'h200);

        // mrmovq 8(%rsp), %rax at 0x200
        imem_bytes = {64'h8, 8'h04, 8'h50};
        sb.push_back(mk(3'd1, 4'h5, 4'h0, 4'h0, 4'h4, 64'h8, 64'h20A));
        step("mrmovq");
        chk("mrmovq.pred", f_pc, 64'h20A);

        // Asynchronous reset away from any clock edge
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_d("async_rst", mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0));
        chk("async_rst.f_pc", f_pc, 64'h0);
        @(negedge clk);
        rst = 1'b0;

`ifdef Y86_PERF_CNT_EN
        imem_bytes = {72'h0, 8'h10};
        repeat (10) @(negedge clk);
        D_stall = 1'b1;
        repeat (5) @(negedge clk);
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        repeat (2) @(negedge clk);
        D_bubble = 1'b0;
        chk("stall_cnt",  {32'd0, stall_cnt},  64'd5);
        chk("bubble_cnt", {32'd0, bubble_cnt}, 64'd2);
        chk("fetch_cnt",  {32'd0, fetch_cnt},  64'd10);
        #2 rst = 1'b1;
        #1;
        chk("rst.stall_cnt",  {32'd0, stall_cnt},  64'd0);
        chk("rst.bubble_cnt", {32'd0, bubble_cnt}, 64'd0);
        chk("rst.fetch_cnt",  {32'd0, fetch_cnt},  64'd0);
        chk("rst.f_pc", f_pc, 64'h0);
        @(negedge clk);
        rst = 1'b0;
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
